// File: rtl/reward_rx.sv
// Receive side of the 5-word reward packet (src, battery, Q-value, cluster, destination).
// Drops packets not addressed to this node or cluster. Otherwise searches the neighbor-ID
// table for the source ID and writes battery status and Q-value into that neighbor's slots.
//
// state  | meaning
// IDLE   | block disabled
// ARMED  | waiting for word 0 (source ID)
// RX1    | waiting for word 1 (battery status)
// RX2    | waiting for word 2 (Q-value)
// RX3    | waiting for word 3 (cluster ID)
// RX4    | waiting for word 4 (destination ID)
// CHECK  | cluster/destination filter, sample neighbor count
// SADDR  | neighbor-ID read address on the bus
// SCMP   | compare returned neighbor ID with source ID
// WBAT   | battery-status write on the bus
// WQV    | Q-value write on the bus
// FIN    | done pulse, packet stored
// DROP   | done + dropped pulse, packet discarded
//
// Registered outputs are loaded on the transition into a state, so each state's
// address/write/done values are on the pins for the duration of that state.

module reward_rx #(
    parameter int WORD_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 11,
    parameter int NEIGHBOR_ID_BASE = 'h048,
    parameter int BATTERY_BASE     = 'h148,
    parameter int QVALUE_BASE      = 'h1C8,
    parameter int MAX_NEIGHBORS    = 64
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    input  logic [6:0]            neighbor_count,
    input  logic [WORD_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] mem_data_out,
    output logic                  wr_en,
    output logic                  done,
    output logic                  dropped,
    output logic [5:0]            found_index
);

    localparam logic [ADDR_WIDTH-1:0] NB_BASE  = ADDR_WIDTH'(NEIGHBOR_ID_BASE);
    localparam logic [ADDR_WIDTH-1:0] BAT_BASE = ADDR_WIDTH'(BATTERY_BASE);
    localparam logic [ADDR_WIDTH-1:0] QV_BASE  = ADDR_WIDTH'(QVALUE_BASE);
    localparam logic [6:0]            MAX_CNT  = 7'(MAX_NEIGHBORS);

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_RX1, S_RX2, S_RX3, S_RX4, S_CHECK,
        S_SADDR, S_SCMP, S_WBAT, S_WQV, S_FIN, S_DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   src_q, src_d, bat_q, bat_d, qv_q, qv_d;
    logic [WORD_WIDTH-1:0]   clu_q, clu_d, dst_q, dst_d;
    logic [5:0]              idx_q, idx_d;
    logic [6:0]              cnt_q, cnt_d;
    logic [6:0]              cnt_clamp;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [WORD_WIDTH-1:0]   mem_data_out_q, mem_data_out_d;
    logic                    wr_en_q, wr_en_d, done_q, done_d, dropped_q, dropped_d;
    logic [5:0]              found_index_q, found_index_d;

    function automatic logic [ADDR_WIDTH-1:0] tbl_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [5:0] i);
        return base + ADDR_WIDTH'({i, 1'b0});
    endfunction

    // Next-state, captured fields and next registered outputs
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        bat_d          = bat_q;
        qv_d           = qv_q;
        clu_d          = clu_q;
        dst_d          = dst_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        address_d      = address_q;
        mem_data_out_d = mem_data_out_q;
        found_index_d  = found_index_q;
        wr_en_d        = 1'b0;
        done_d         = 1'b0;
        dropped_d      = 1'b0;
        cnt_clamp      = (neighbor_count > MAX_CNT) ? MAX_CNT : neighbor_count;

        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARMED;
                S_ARMED: if (rx_valid) begin src_d = rx_data; state_d = S_RX1; end
                S_RX1:   if (rx_valid) begin bat_d = rx_data; state_d = S_RX2; end
                S_RX2:   if (rx_valid) begin qv_d  = rx_data; state_d = S_RX3; end
                S_RX3:   if (rx_valid) begin clu_d = rx_data; state_d = S_RX4; end
                S_RX4:   if (rx_valid) begin dst_d = rx_data; state_d = S_CHECK; end
                S_CHECK: begin
                    cnt_d = cnt_clamp;
                    if (clu_q != MY_CLUSTER_ID || dst_q != MY_NODE_ID || cnt_clamp == 7'd0) begin
                        state_d   = S_DROP;
                        done_d    = 1'b1;
                        dropped_d = 1'b1;
                    end else begin
                        idx_d     = 6'd0;
                        address_d = NB_BASE;
                        state_d   = S_SADDR;
                    end
                end
                S_SADDR: state_d = S_SCMP;
                S_SCMP: begin
                    if (mem_data_in == src_q) begin
                        found_index_d  = idx_q;
                        address_d      = tbl_addr(BAT_BASE, idx_q);
                        mem_data_out_d = bat_q;
                        wr_en_d        = 1'b1;
                        state_d        = S_WBAT;
                    end else if ({1'b0, idx_q} == 7'(cnt_q - 7'd1)) begin
                        done_d    = 1'b1;
                        dropped_d = 1'b1;
                        state_d   = S_DROP;
                    end else begin
                        idx_d     = 6'(idx_q + 6'd1);
                        address_d = tbl_addr(NB_BASE, 6'(idx_q + 6'd1));
                        state_d   = S_SADDR;
                    end
                end
                S_WBAT: begin
                    address_d      = tbl_addr(QV_BASE, idx_q);
                    mem_data_out_d = qv_q;
                    wr_en_d        = 1'b1;
                    state_d        = S_WQV;
                end
                S_WQV: begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end
                S_FIN:   state_d = S_ARMED;
                S_DROP:  state_d = S_ARMED;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q        <= S_IDLE;
            src_q          <= '0;
            bat_q          <= '0;
            qv_q           <= '0;
            clu_q          <= '0;
            dst_q          <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            address_q      <= '0;
            mem_data_out_q <= '0;
            found_index_q  <= '0;
            wr_en_q        <= 1'b0;
            done_q         <= 1'b0;
            dropped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            bat_q          <= bat_d;
            qv_q           <= qv_d;
            clu_q          <= clu_d;
            dst_q          <= dst_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            address_q      <= address_d;
            mem_data_out_q <= mem_data_out_d;
            found_index_q  <= found_index_d;
            wr_en_q        <= wr_en_d;
            done_q         <= done_d;
            dropped_q      <= dropped_d;
        end
    end

    assign address      = address_q;
    assign mem_data_out = mem_data_out_q;
    assign wr_en        = wr_en_q;
    assign done         = done_q;
    assign dropped      = dropped_q;
    assign found_index  = found_index_q;

endmodule

// File: tb/tb_reward_rx.sv
// Randomized and directed bench for reward_rx with a synchronous-read memory model
// and a table-search reference model.

module tb_reward_rx;

    localparam logic [10:0] NB  = 11'h048;
    localparam logic [10:0] BAT = 11'h148;
    localparam logic [10:0] QV  = 11'h1C8;
    localparam logic [15:0] MY_C = 16'h00C3;
    localparam logic [15:0] MY_N = 16'h0042;

    logic        clock = 1'b0;
    logic        nrst, en, rx_valid, wr_en, done, dropped;
    logic [15:0] rx_data, mem_data_in, mem_data_out;
    logic [6:0]  neighbor_count;
    logic [10:0] address;
    logic [5:0]  found_index;

    logic [15:0] mem [0:2047];
    logic [15:0] tbl [0:127];
    logic [10:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    bit          vpat[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          n_chk = 0;
    int          n_bad = 0;
    int          last_found = 0;

    reward_rx dut (
        .clock(clock), .nrst(nrst), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
        .MY_NODE_ID(MY_N), .MY_CLUSTER_ID(MY_C), .neighbor_count(neighbor_count),
        .mem_data_in(mem_data_in), .address(address), .mem_data_out(mem_data_out),
        .wr_en(wr_en), .done(done), .dropped(dropped), .found_index(found_index)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: data for the address presented this cycle arrives next cycle
    always @(posedge clock) begin
        mem_data_in <= mem[address];
        cyc <= cyc + 1;
    end

    // Record writes and done pulses mid-cycle
    always @(negedge clock) begin
        if (wr_en) begin
            wa.push_back(address);
            wd.push_back(mem_data_out);
            wc.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_tbl();
        for (int i = 0; i < 128; i++) mem[NB + 11'(2 * i)] = tbl[i];
    endtask

    // Reference: first table hit within the clamped count, or -1 when dropped.
    // lat = cycles from the 5th accepting edge to the edge that raises done.
    function automatic int model_idx(input logic [15:0] s, input logic [15:0] c,
                                     input logic [15:0] d, input int cnt, output int lat);
        int lim;
        lim = (cnt > 64) ? 64 : cnt;
        if (c != MY_C || d != MY_N || lim == 0) begin
            lat = 1;
            return -1;
        end
        for (int i = 0; i < lim; i++) begin
            if (tbl[i] == s) begin
                lat = 5 + 2 * i;
                return i;
            end
        end
        lat = 1 + 2 * lim;
        return -1;
    endfunction

    // Drive one packet; valid gaps come from vpat, defaulting to back-to-back words
    task automatic send_words(input logic [15:0] s, input logic [15:0] b, input logic [15:0] q,
                              input logic [15:0] c, input logic [15:0] d);
        logic [15:0] w [5];
        int n;
        bit v;
        w = '{s, b, q, c, d};
        n = 0;
        while (n < 5) begin
            v = 1'b1;
            if (vpat.size() > 0) v = vpat.pop_front();
            rx_valid = v;
            rx_data  = v ? w[n] : 16'($urandom);
            @(negedge clock);
            if (v) n++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input logic [15:0] s, input logic [15:0] b,
                           input logic [15:0] q, input logic [15:0] c, input logic [15:0] d);
        int k, lat, e5, t;
        bit got;
        k = model_idx(s, c, d, int'(neighbor_count), lat);
        wa.delete(); wd.delete(); wc.delete();
        send_words(s, b, q, c, d);
        e5  = cyc;
        got = 1'b0;
        for (t = 0; t < 400; t++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clock);
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_latency"}, 32'(cyc - e5), 32'(lat));
        chk({tag, "_dropped"}, 32'(dropped), 32'(k < 0));
        if (k >= 0) begin
            last_found = k;
            chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
            if (wa.size() == 2) begin
                chk({tag, "_bat_addr"}, 32'(wa[0]), 32'(BAT + 11'(2 * k)));
                chk({tag, "_bat_data"}, 32'(wd[0]), 32'(b));
                chk({tag, "_qv_addr"}, 32'(wa[1]), 32'(QV + 11'(2 * k)));
                chk({tag, "_qv_data"}, 32'(wd[1]), 32'(q));
                chk({tag, "_wr_gap"}, 32'(wc[1] - wc[0]), 32'd1);
            end
        end else begin
            chk({tag, "_nwr"}, 32'(wa.size()), 32'd0);
        end
        chk({tag, "_found"}, 32'(found_index), 32'(last_found));
        @(negedge clock);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dc;
        logic [15:0] s, c, d;
        nrst = 1'b0; en = 1'b0; rx_valid = 1'b0; rx_data = '0; neighbor_count = 7'd3;
        for (int i = 0; i < 2048; i++) mem[i] = 16'hFFFF;
        for (int i = 0; i < 128; i++) tbl[i] = 16'hA000 + 16'(i);
        tbl[0] = 16'h0010; tbl[1] = 16'h0022; tbl[2] = 16'h0035;
        load_tbl();
        repeat (3) @(negedge clock);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_wdata", 32'(mem_data_out), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        chk("rst_found", 32'(found_index), 32'd0);
        nrst = 1'b1; en = 1'b1;
        @(negedge clock);

        run_pkt("basic", 16'h0022, 16'h0050, 16'h0123, MY_C, MY_N);
        run_pkt("bad_dst", 16'h0022, 16'h0050, 16'h0123, MY_C, MY_N + 16'd1);
        run_pkt("bad_clu", 16'h0022, 16'h0050, 16'h0123, MY_C + 16'd1, MY_N);
        run_pkt("no_hit", 16'h0099, 16'h0050, 16'h0123, MY_C, MY_N);
        vpat = '{1, 0, 0, 1, 1, 0, 1, 1};
        run_pkt("gaps", 16'h0022, 16'h0050, 16'h0123, MY_C, MY_N);
        neighbor_count = 7'd0;
        run_pkt("cnt0", 16'h0010, 16'h0001, 16'h0002, MY_C, MY_N);

        // en dropped while comparing entry 0: back to IDLE, nothing written
        neighbor_count = 7'd3;
        wa.delete();
        dc = done_cnt;
        send_words(16'h0035, 16'h0777, 16'h0888, MY_C, MY_N);
        repeat (2) @(negedge clock);
        en = 1'b0;
        repeat (8) @(negedge clock);
        chk("en_off_nwr", 32'(wa.size()), 32'd0);
        chk("en_off_done", 32'(done_cnt - dc), 32'd0);
        en = 1'b1;
        @(negedge clock);
        run_pkt("after_en", 16'h0035, 16'h0777, 16'h0888, MY_C, MY_N);

        // reset during the battery write
        wa.delete();
        send_words(16'h0010, 16'h0AAA, 16'h0BBB, MY_C, MY_N);
        repeat (3) @(negedge clock);
        chk("wbat_wr_en", 32'(wr_en), 32'd1);
        nrst = 1'b0;
        @(negedge clock);
        chk("rst_wbat_addr", 32'(address), 32'd0);
        chk("rst_wbat_wdata", 32'(mem_data_out), 32'd0);
        chk("rst_wbat_wr", 32'(wr_en), 32'd0);
        chk("rst_wbat_done", 32'({done, dropped}), 32'd0);
        chk("rst_wbat_found", 32'(found_index), 32'd0);
        last_found = 0;
        nrst = 1'b1;
        @(negedge clock);
        chk("rst_wbat_nwr", 32'(wa.size()), 32'd1);

        // clamp of an oversized count, back-to-back packets
        neighbor_count = 7'd100;
        dc = done_cnt;
        run_pkt("b2b_0", 16'h0010, 16'h1111, 16'h2222, MY_C, MY_N);
        run_pkt("b2b_2", 16'h0035, 16'h3333, 16'h4444, MY_C, MY_N);
        chk("b2b_done_cnt", 32'(done_cnt - dc), 32'd2);
        run_pkt("clamp_63", tbl[63], 16'h5555, 16'h6666, MY_C, MY_N);
        run_pkt("clamp_64", tbl[64], 16'h5555, 16'h6666, MY_C, MY_N);
        neighbor_count = 7'd127;
        run_pkt("clamp_127", tbl[64], 16'h5555, 16'h6666, MY_C, MY_N);

        // randomized packets against the reference model; small ID range forces duplicates
        for (int p = 0; p < 40; p++) begin
            if (p % 10 == 0) begin
                for (int i = 0; i < 128; i++) tbl[i] = 16'h0100 + 16'($urandom_range(0, 40));
                load_tbl();
            end
            neighbor_count = 7'($urandom_range(0, 90));
            s = ($urandom_range(0, 3) == 0) ? 16'h0100 + 16'($urandom_range(0, 60))
                                            : tbl[$urandom_range(0, 80)];
            c = ($urandom_range(0, 9) == 0) ? 16'($urandom) : MY_C;
            d = ($urandom_range(0, 9) == 0) ? 16'($urandom) : MY_N;
            for (int g = 0; g < int'($urandom_range(0, 8)); g++) vpat.push_back(1'($urandom));
            run_pkt("rand", s, 16'($urandom), 16'($urandom), c, d);
            vpat.delete();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
